// File: rtl/vta_load_ctrl.sv
// VTA load-stage sequencer: decodes load instructions, handles dependency tokens
// and starts the input/weight tensor-load engines. Optional perf counters: VTA_LOAD_CTRL_PERF_EN.
module vta_load_ctrl #(
  parameter int unsigned INST_W    = 128,
  parameter int unsigned XSIZE_LSB = 80
`ifdef VTA_LOAD_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W    = 32
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_q,
  input  logic              tok_in_valid,
  output logic              tok_in_ready,
  output logic              tok_out_valid,
  input  logic              tok_out_ready,
  output logic              inp_start,
  input  logic              inp_done,
  output logic              wgt_start,
  input  logic              wgt_done,
  output logic              busy,
  output logic              err_illegal
`ifdef VTA_LOAD_CTRL_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_inp_cnt,
  output logic [PERF_W-1:0] perf_wgt_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_EXEC, S_WAIT, S_PUSH} state_e;
  typedef enum logic [1:0] {K_ILL, K_INP, K_WGT, K_SYNC} kind_e;

  // Classify an instruction word into input / weight / sync / illegal.
  function automatic kind_e decode(input logic [INST_W-1:0] v);
    logic [2:0] op;
    logic [2:0] mem_id;
    logic       xsize_zero;
    kind_e      k;
    op         = v[2:0];
    mem_id     = v[9:7];
    xsize_zero = (v[XSIZE_LSB +: 16] == 16'd0);
    k          = K_ILL;
    if (op == 3'd0) begin
      if (mem_id == 3'b010)      k = xsize_zero ? K_SYNC : K_INP;
      else if (mem_id == 3'b001) k = xsize_zero ? K_SYNC : K_WGT;
    end
    return k;
  endfunction

  state_e              state_q, state_d;
  logic [INST_W-1:0]   inst_d;
  logic                inst_ready_q, inst_ready_d;
  logic                tok_in_ready_q, tok_in_ready_d;
  logic                tok_out_valid_q, tok_out_valid_d;
  logic                inp_start_q, inp_start_d;
  logic                wgt_start_q, wgt_start_d;
  logic                busy_q, busy_d;
  logic                err_illegal_q, err_illegal_d;
  kind_e               kind_cur, kind_nxt;
  logic                push_cur;

  // Next state plus registered outputs derived from the next state.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    err_illegal_d = err_illegal_q;
    kind_cur      = decode(inst_q);
    push_cur      = inst_q[6];

    case (state_q)
      S_IDLE: begin
        if (inst_ready_q && inst_valid) begin
          inst_d  = inst;
          state_d = inst[4] ? S_POP : S_EXEC;
        end
      end
      S_POP: begin
        if (tok_in_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (kind_cur == K_INP || kind_cur == K_WGT) begin
          state_d = S_WAIT;
        end else begin
          state_d = push_cur ? S_PUSH : S_IDLE;
          if (kind_cur == K_ILL) err_illegal_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Only the selected engine's done is honoured.
        if ((kind_cur == K_INP && inp_done) || (kind_cur == K_WGT && wgt_done))
          state_d = push_cur ? S_PUSH : S_IDLE;
      end
      S_PUSH: begin
        if (tok_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    kind_nxt        = decode(inst_d);
    inst_ready_d    = (state_d == S_IDLE);
    tok_in_ready_d  = (state_d == S_POP);
    tok_out_valid_d = (state_d == S_PUSH);
    busy_d          = (state_d != S_IDLE);
    inp_start_d     = (state_d == S_EXEC) && (kind_nxt == K_INP);
    wgt_start_d     = (state_d == S_EXEC) && (kind_nxt == K_WGT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      inst_q          <= '0;
      inst_ready_q    <= 1'b0;
      tok_in_ready_q  <= 1'b0;
      tok_out_valid_q <= 1'b0;
      inp_start_q     <= 1'b0;
      wgt_start_q     <= 1'b0;
      busy_q          <= 1'b0;
      err_illegal_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      inst_q          <= inst_d;
      inst_ready_q    <= inst_ready_d;
      tok_in_ready_q  <= tok_in_ready_d;
      tok_out_valid_q <= tok_out_valid_d;
      inp_start_q     <= inp_start_d;
      wgt_start_q     <= wgt_start_d;
      busy_q          <= busy_d;
      err_illegal_q   <= err_illegal_d;
    end
  end

  assign inst_ready    = inst_ready_q;
  assign tok_in_ready  = tok_in_ready_q;
  assign tok_out_valid = tok_out_valid_q;
  assign inp_start     = inp_start_q;
  assign wgt_start     = wgt_start_q;
  assign busy          = busy_q;
  assign err_illegal   = err_illegal_q;

`ifdef VTA_LOAD_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_inp_q, perf_inp_d;
  logic [PERF_W-1:0] perf_wgt_q, perf_wgt_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Wrapping event counters; clear wins over increment.
  always_comb begin
    perf_inp_d   = perf_inp_q + PERF_W'(inp_start_q);
    perf_wgt_d   = perf_wgt_q + PERF_W'(wgt_start_q);
    perf_stall_d = perf_stall_q + PERF_W'((state_q == S_POP) && !tok_in_valid);
    if (perf_clr) begin
      perf_inp_d   = '0;
      perf_wgt_d   = '0;
      perf_stall_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_inp_q   <= '0;
      perf_wgt_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_inp_q   <= perf_inp_d;
      perf_wgt_q   <= perf_wgt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_inp_cnt   = perf_inp_q;
  assign perf_wgt_cnt   = perf_wgt_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_vta_load_ctrl.sv
// Randomized bench for vta_load_ctrl: each instruction's handshakes and latency are
// predicted from the field-level decode rules and the per-state cycle costs.
module tb_vta_load_ctrl;
  localparam int unsigned INST_W    = 128;
  localparam int unsigned XSIZE_LSB = 80;
  localparam int KIND_ILL = 0, KIND_INP = 1, KIND_WGT = 2, KIND_SYNC = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              inst_valid = 1'b0;
  logic              inst_ready;
  logic [INST_W-1:0] inst = '0;
  logic [INST_W-1:0] inst_q;
  logic              tok_in_valid = 1'b0;
  logic              tok_in_ready;
  logic              tok_out_valid;
  logic              tok_out_ready = 1'b0;
  logic              inp_start;
  logic              inp_done = 1'b0;
  logic              wgt_start;
  logic              wgt_done = 1'b0;
  logic              busy;
  logic              err_illegal;
`ifdef VTA_LOAD_CTRL_PERF_EN
  logic              perf_clr = 1'b0;
  logic [31:0]       perf_inp_cnt, perf_wgt_cnt, perf_stall_cnt;
`endif

  vta_load_ctrl #(.INST_W(INST_W), .XSIZE_LSB(XSIZE_LSB)) dut (
    .clock(clock), .reset_n(reset_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_q(inst_q),
    .tok_in_valid(tok_in_valid), .tok_in_ready(tok_in_ready),
    .tok_out_valid(tok_out_valid), .tok_out_ready(tok_out_ready),
    .inp_start(inp_start), .inp_done(inp_done),
    .wgt_start(wgt_start), .wgt_done(wgt_done),
    .busy(busy), .err_illegal(err_illegal)
`ifdef VTA_LOAD_CTRL_PERF_EN
    , .perf_clr(perf_clr), .perf_inp_cnt(perf_inp_cnt),
    .perf_wgt_cnt(perf_wgt_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  int exp_inp = 0, exp_wgt = 0, exp_stall = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Field-level classification straight from the instruction format.
  function automatic int exp_kind(input logic [INST_W-1:0] v);
    logic [15:0] xs;
    xs = v[XSIZE_LSB +: 16];
    if (v[2:0] != 3'd0) return KIND_ILL;
    if (v[9:7] != 3'b010 && v[9:7] != 3'b001) return KIND_ILL;
    if (xs == 16'd0) return KIND_SYNC;
    return (v[9:7] == 3'b010) ? KIND_INP : KIND_WGT;
  endfunction

  function automatic logic [INST_W-1:0] mk_inst(input int kind, input bit pop, input bit push);
    logic [INST_W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[4] = pop;
    v[6] = push;
    case (kind)
      KIND_INP: begin v[2:0] = 3'd0; v[9:7] = 3'b010; v[XSIZE_LSB +: 16] = 16'($urandom_range(1, 65535)); end
      KIND_WGT: begin v[2:0] = 3'd0; v[9:7] = 3'b001; v[XSIZE_LSB +: 16] = 16'($urandom_range(1, 65535)); end
      KIND_SYNC: begin
        v[2:0] = 3'd0;
        v[9:7] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b001;
        v[XSIZE_LSB +: 16] = 16'd0;
      end
      default: begin
        if ($urandom_range(0, 1) == 0) v[2:0] = 3'($urandom_range(1, 7));
        else begin
          v[2:0] = 3'd0;
          v[9:7] = 3'($urandom_range(3, 8) & 7);
        end
      end
    endcase
    return v;
  endfunction

  // Drive one instruction end to end and predict every observable step.
  task automatic run_inst(input logic [INST_W-1:0] v, input int pst, input int dd,
                          input int ost, input bit spur);
    int  k, cyc, exp_cyc;
    bit  pop, push, eng;
    k    = exp_kind(v);
    pop  = v[4];
    push = v[6];
    eng  = (k == KIND_INP) || (k == KIND_WGT);
    for (int i = 0; i < 8 && inst_ready !== 1'b1; i++) tick;
    check("inst_ready_idle", inst_ready, 1);
    cyc = 0;
    inst_valid = 1'b1;
    inst = v;
    tick; cyc++;
    inst_valid = 1'b0;
    inst = {$urandom, $urandom, $urandom, $urandom};
    check("inst_q_latch", inst_q, v);
    check("busy_after_accept", busy, 1);
    check("inst_ready_busy", inst_ready, 0);
    if (pop) begin
      for (int i = 0; i < pst; i++) begin
        tok_in_valid = 1'b0;
        check("tok_in_ready_pop", tok_in_ready, 1);
        check("no_start_in_pop", {inp_start, wgt_start}, 0);
        exp_stall++;
        tick; cyc++;
      end
      tok_in_valid = 1'b1;
      check("tok_in_ready_hs", tok_in_ready, 1);
      tick; cyc++;
      tok_in_valid = 1'b0;
    end else begin
      tok_in_valid = 1'($urandom_range(0, 1));
    end
    check("tok_in_ready_exec", tok_in_ready, 0);
    check("inp_start_exec", inp_start, (k == KIND_INP));
    check("wgt_start_exec", wgt_start, (k == KIND_WGT));
    if (k == KIND_INP) exp_inp++;
    if (k == KIND_WGT) exp_wgt++;
    tick; cyc++;
    tok_in_valid = 1'b0;
    if (k == KIND_ILL) exp_err = 1;
    check("err_illegal_exec", err_illegal, exp_err);
    if (eng) begin
      for (int i = 0; i < dd; i++) begin
        check("no_start_in_wait", {inp_start, wgt_start}, 0);
        check("busy_wait", busy, 1);
        check("tok_out_wait", tok_out_valid, 0);
        if (k == KIND_INP) begin inp_done = 1'b0; wgt_done = spur; end
        else begin wgt_done = 1'b0; inp_done = spur; end
        tick; cyc++;
      end
      check("inst_q_stable", inst_q, v);
      inp_done = (k == KIND_INP);
      wgt_done = (k == KIND_WGT);
      tick; cyc++;
      inp_done = 1'b0;
      wgt_done = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < ost; i++) begin
        tok_out_ready = 1'b0;
        check("tok_out_hold", tok_out_valid, 1);
        tick; cyc++;
      end
      check("tok_out_hs", tok_out_valid, 1);
      tok_out_ready = 1'b1;
      tick; cyc++;
      tok_out_ready = 1'b0;
    end
    exp_cyc = 2 + (pop ? pst + 1 : 0) + (eng ? dd + 1 : 0) + (push ? ost + 1 : 0);
    check("latency", cyc, exp_cyc);
    check("tok_out_drop", tok_out_valid, 0);
    check("inst_ready_back", inst_ready, 1);
    check("busy_idle", busy, 0);
    check("err_sticky", err_illegal, exp_err);
`ifdef VTA_LOAD_CTRL_PERF_EN
    check("perf_inp", perf_inp_cnt, exp_inp);
    check("perf_wgt", perf_wgt_cnt, exp_wgt);
    check("perf_stall", perf_stall_cnt, exp_stall);
`endif
  endtask

  initial begin
    logic [INST_W-1:0] v;
    #3;
    check("rst_busy", busy, 0);
    check("rst_inst_ready", inst_ready, 0);
    check("rst_inst_q", inst_q, 0);
    check("rst_err", err_illegal, 0);
    check("rst_starts", {inp_start, wgt_start, tok_in_ready, tok_out_valid}, 0);
    @(negedge clock); reset_n = 1'b1;
    tick;

    // Input load, no tokens, done four cycles into WAIT.
    v = mk_inst(KIND_INP, 0, 0);
    v[XSIZE_LSB +: 16] = 16'd4;
    run_inst(v, 0, 3, 0, 0);
    // Weight load with a three-cycle token stall.
    run_inst(mk_inst(KIND_WGT, 1, 0), 3, 1, 0, 0);
    // Sync with push and two cycles of back-pressure.
    v = mk_inst(KIND_SYNC, 0, 1);
    v[9:7] = 3'b010;
    run_inst(v, 0, 0, 2, 0);
    // Illegal mem_id with both tokens.
    v = mk_inst(KIND_INP, 1, 1);
    v[9:7] = 3'b100;
    run_inst(v, 0, 0, 0, 0);
    // Spurious weight done while waiting on input.
    run_inst(mk_inst(KIND_INP, 0, 0), 0, 3, 0, 1);

    // Asynchronous reset while an input load is in WAIT.
    v = mk_inst(KIND_INP, 0, 1);
    inst_valid = 1'b1; inst = v;
    tick; inst_valid = 1'b0;
    tick; tick;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {inst_ready, inp_start, wgt_start, tok_in_ready, tok_out_valid}, 0);
    check("arst_err", err_illegal, 0);
    check("arst_inst_q", inst_q, 0);
    exp_err = 0; exp_inp = 0; exp_wgt = 0; exp_stall = 0;
    @(negedge clock); reset_n = 1'b1;
    tick;
    run_inst(mk_inst(KIND_WGT, 0, 0), 0, 0, 0, 0);

`ifdef VTA_LOAD_CTRL_PERF_EN
    perf_clr = 1'b1; tick; perf_clr = 1'b0;
    check("perf_clr", {perf_inp_cnt, perf_wgt_cnt, perf_stall_cnt}, 0);
    exp_inp = 0; exp_wgt = 0; exp_stall = 0;
`endif

    for (int n = 0; n < 60; n++) begin
      v = mk_inst($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_inst(v, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
